// File: rtl/cmult_sched.sv
// Round-robin scheduler sharing one Karatsuba complex multiplier between NUM_REQ requesters.
// Optional feature macro: CMULT_SCHED_PRIO0_EN gives requester 0 strict priority over the round-robin.
module cmult_sched #(
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ),
  localparam int unsigned PROD_W  = 2 * DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a_real,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a_img,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b_real,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b_img,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ID_W-1:0]             out_id,
  output logic [PROD_W-1:0]           out_real,
  output logic [PROD_W-1:0]           out_img
);

`ifdef CMULT_SCHED_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  logic              s1_valid;
  logic [ID_W-1:0]   s1_id;
  logic [DATA_W-1:0] s1_ar, s1_ai, s1_br, s1_bi;
  logic [ID_W-1:0]   rr_ptr;

  logic              out_open, s1_adv, s1_open;
  logic              rr_found, grant_valid, ptr_upd;
  logic [ID_W-1:0]   rr_id, grant_id, ptr_next, cand;
  logic [PROD_W-1:0] xar, xai, xbr, xbi, k1, k2, k3;
  logic [PROD_W-1:0] mul_real, mul_img;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  assign out_open = !out_valid || out_ready;
  assign s1_adv   = s1_valid && out_open;
  assign s1_open  = !s1_valid || s1_adv;

  // Grant selection: first valid requester at or after rr_ptr, optionally pre-empted by requester 0.
  always_comb begin
    rr_found    = 1'b0;
    rr_id       = '0;
    cand        = '0;
    grant_valid = 1'b0;
    grant_id    = '0;
    ptr_upd     = 1'b0;
    req_ready   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = wrap_add(rr_ptr, k);
      if (!rr_found && req_valid[cand] && !(PRIO0 && cand == '0)) begin
        rr_found = 1'b1;
        rr_id    = cand;
      end
    end
    if (s1_open && !rst) begin
      if (PRIO0 && req_valid[0]) begin
        grant_valid = 1'b1;
        grant_id    = '0;
      end else if (rr_found) begin
        grant_valid = 1'b1;
        grant_id    = rr_id;
        ptr_upd     = 1'b1;
      end
    end
    if (grant_valid) req_ready[grant_id] = 1'b1;
  end

  assign ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  // Karatsuba complex multiply, three products, all arithmetic modulo 2^PROD_W.
  always_comb begin
    xar      = PROD_W'(s1_ar);
    xai      = PROD_W'(s1_ai);
    xbr      = PROD_W'(s1_br);
    xbi      = PROD_W'(s1_bi);
    k1       = xbr * (xar + xai);
    k2       = xar * (xbi - xbr);
    k3       = xai * (xbr + xbi);
    mul_real = k1 - k3;
    mul_img  = k1 + k2;
  end

  // Operand stage, result stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s1_ar     <= '0;
      s1_ai     <= '0;
      s1_br     <= '0;
      s1_bi     <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_real  <= '0;
      out_img   <= '0;
      rr_ptr    <= '0;
    end else begin
      if (s1_open) begin
        s1_valid <= grant_valid;
        if (grant_valid) begin
          s1_id <= grant_id;
          s1_ar <= req_a_real[32'(grant_id) * DATA_W +: DATA_W];
          s1_ai <= req_a_img [32'(grant_id) * DATA_W +: DATA_W];
          s1_br <= req_b_real[32'(grant_id) * DATA_W +: DATA_W];
          s1_bi <= req_b_img [32'(grant_id) * DATA_W +: DATA_W];
        end
      end
      if (out_open) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_id   <= s1_id;
          out_real <= mul_real;
          out_img  <= mul_img;
        end
      end
      if (ptr_upd) rr_ptr <= ptr_next;
    end
  end

endmodule

// File: tb/tb_cmult_sched.sv
// Directed self-checking bench for cmult_sched (DATA_W=8, NUM_REQ=4).
module tb_cmult_sched;
  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [NR*DW-1:0] a_re, a_im, b_re, b_im;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_id;
  logic [15:0]   out_real, out_img;

  int n_checks = 0;
  int n_errors = 0;

  cmult_sched #(.DATA_W(DW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a_real(a_re), .req_a_img(a_im), .req_b_real(b_re), .req_b_img(b_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_real(out_real), .out_img(out_img)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] ar, input logic [7:0] ai,
                        input logic [7:0] br, input logic [7:0] bi);
    a_re[i*DW +: DW] = ar;
    a_im[i*DW +: DW] = ai;
    b_re[i*DW +: DW] = br;
    b_im[i*DW +: DW] = bi;
  endtask

  task automatic check_out(input string tag, input logic [1:0] id, input logic [15:0] re,
                           input logic [15:0] im);
    check({tag, "_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_id"},    64'(out_id),    64'(id));
    check({tag, "_real"},  64'(out_real),  64'(re));
    check({tag, "_img"},   64'(out_img),   64'(im));
  endtask

  // Requester i operand set: A=(i+1)+1i, B=2+3i -> real=2(i+1)-3, img=3(i+1)+2.
  logic [15:0] rr_re [4] = '{16'hFFFF, 16'h0001, 16'h0003, 16'h0005};
  logic [15:0] rr_im [4] = '{16'h0005, 16'h0008, 16'h000B, 16'h000E};
  int          rr_order [6] = '{2, 3, 0, 1, 2, 3};
`ifdef CMULT_SCHED_PRIO0_EN
  int          pr_order [4] = '{0, 0, 0, 0};
`else
  int          pr_order [4] = '{3, 0, 3, 0};
`endif

  initial begin
    rst = 1'b1; req_valid = '0; out_ready = 1'b1;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;

    // Reset state with requesters already asserting valid.
    req_valid = '1;
    tick(); tick(); #1;
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_real", 64'(out_real), 64'(0));
    check("rst_out_id", 64'(out_id), 64'(0));

    // Single op from requester 2: (3+4i)(5+6i).
    set_op(2, 8'd3, 8'd4, 8'd5, 8'd6);
    rst = 1'b0; req_valid = 4'b0100; #1;
    check("single_ready", 64'(req_ready), 64'(4'b0100));
    tick(); req_valid = '0; #1;
    check("single_lat1", 64'(out_valid), 64'(0));
    tick(); #1;
    check_out("single", 2'd2, 16'hFFF7, 16'h0026);

    // Wrap-around: req 3 squares 255i, req 1 squares 255; pointer sits at 3.
    set_op(3, 8'd0, 8'd255, 8'd0, 8'd255);
    set_op(1, 8'd255, 8'd0, 8'd255, 8'd0);
    req_valid = 4'b1010; #1;
    check("wrap_ready0", 64'(req_ready), 64'(4'b1000));
    tick(); req_valid = 4'b0010; #1;
    check("wrap_ready1", 64'(req_ready), 64'(4'b0010));
    tick(); req_valid = '0; #1;
    check_out("wrap_a", 2'd3, 16'h01FF, 16'h0000);
    tick(); #1;
    check_out("wrap_b", 2'd1, 16'hFE01, 16'h0000);
    tick(); #1;
    check("wrap_drain", 64'(out_valid), 64'(0));

    // Round-robin with all requesters valid; pointer starts at 2.
    for (int i = 0; i < 4; i++) set_op(i, 8'(i + 1), 8'd1, 8'd2, 8'd3);
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      if (k == 6) req_valid = '0;
      #1;
      if (k < 6) check("rr_ready", 64'(req_ready), 64'(4'b0001 << rr_order[k]));
      else       check("rr_ready_idle", 64'(req_ready), 64'(0));
      if (k >= 2) check_out("rr_out", 2'(rr_order[k-2]), rr_re[rr_order[k-2]], rr_im[rr_order[k-2]]);
      tick();
    end
    #1;
    check("rr_drain", 64'(out_valid), 64'(0));

    // Back-pressure: 5 stalled cycles, pointer at 0.
    out_ready = 1'b0; req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      if (k == 5) begin out_ready = 1'b1; req_valid = '0; end
      #1;
      case (k)
        0: begin check("bp_ready0", 64'(req_ready), 64'(4'b0001)); check("bp_v0", 64'(out_valid), 64'(0)); end
        1: begin check("bp_ready1", 64'(req_ready), 64'(4'b0010)); check("bp_v1", 64'(out_valid), 64'(0)); end
        2, 3, 4, 5: begin
          check("bp_ready_stall", 64'(req_ready), 64'(0));
          check_out("bp_hold", 2'd0, rr_re[0], rr_im[0]);
        end
        6: check_out("bp_second", 2'd1, rr_re[1], rr_im[1]);
        default: check("bp_drain", 64'(out_valid), 64'(0));
      endcase
      tick();
    end

    // Reset with both stages full; pointer at 2 before reset.
    out_ready = 1'b0; req_valid = 4'b0110; #1;
    check("mr_ready0", 64'(req_ready), 64'(4'b0100));
    tick(); #1;
    check("mr_ready1", 64'(req_ready), 64'(4'b0010));
    tick(); rst = 1'b1; #1;
    check("mr_ready_rst", 64'(req_ready), 64'(0));
    check("mr_full", 64'(out_valid), 64'(1));
    tick(); #1;
    check("mr_cleared", 64'(out_valid), 64'(0));
    check("mr_ready_after", 64'(req_ready), 64'(0));
    rst = 1'b0; req_valid = '0; out_ready = 1'b1;
    tick(); #1;
    check("mr_no_stale0", 64'(out_valid), 64'(0));
    tick(); #1;
    check("mr_no_stale1", 64'(out_valid), 64'(0));
    req_valid = 4'b0110; #1;
    check("mr_ptr_zero", 64'(req_ready), 64'(4'b0010));
    tick(); req_valid = '0;
    tick(); #1;
    check_out("mr_fresh", 2'd1, rr_re[1], rr_im[1]);

    // Requesters 0 and 3 continuously valid; pointer at 2.
    req_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("prio_ready", 64'(req_ready), 64'(4'b0001 << pr_order[k]));
      tick();
    end
    req_valid = '0;
    tick(); #1;
    check_out("prio_last", 2'(pr_order[3]), rr_re[pr_order[3]], rr_im[pr_order[3]]);
    tick(); #1;
    check("prio_drain", 64'(out_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
